// File: rtl/element_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// element_cmd_arbiter_if
// Bundles the signals between the per-core command decoders, the shared
// element command port and the element_cmd_arbiter.
//   req_valid/req_ready        : per-requester handshake (ready = 1-cycle ack)
//   req_envstart..req_trigt    : packed per-requester command fields, slice i
//   tcnt, elem_busy            : element time counter and busy flag
//   cmdstb, envstart..pini     : issued command towards the element
//   grant_id, late_cnt         : last issued requester, saturating late count
// Modports: slave  = arbiter view, master = requester/element view.
// ---------------------------------------------------------------------------
interface element_cmd_arbiter_if #(
  parameter int NREQ           = 4,
  parameter int ENV_ADDRWIDTH  = 32,
  parameter int FREQ_ADDRWIDTH = 32,
  parameter int TCNTWIDTH      = 27
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [NREQ*ENV_ADDRWIDTH-1:0]  req_envstart;
  logic [NREQ*ENV_ADDRWIDTH-1:0]  req_envlength;
  logic [NREQ*16-1:0]             req_ampx;
  logic [NREQ*FREQ_ADDRWIDTH-1:0] req_freqaddr;
  logic [NREQ*17-1:0]             req_pini;
  logic [NREQ*TCNTWIDTH-1:0]      req_trigt;
  logic [TCNTWIDTH-1:0]           tcnt;
  logic                           elem_busy;
  logic                           cmdstb;
  logic [ENV_ADDRWIDTH-1:0]       envstart;
  logic [ENV_ADDRWIDTH-1:0]       envlength;
  logic [15:0]                    ampx;
  logic [FREQ_ADDRWIDTH-1:0]      freqaddr;
  logic [16:0]                    pini;
  logic [IDW-1:0]                 grant_id;
  logic [15:0]                    late_cnt;

  modport slave (
    input  req_valid, req_envstart, req_envlength, req_ampx, req_freqaddr,
           req_pini, req_trigt, tcnt, elem_busy,
    output req_ready, cmdstb, envstart, envlength, ampx, freqaddr, pini,
           grant_id, late_cnt
  );

  modport master (
    output req_valid, req_envstart, req_envlength, req_ampx, req_freqaddr,
           req_pini, req_trigt, tcnt, elem_busy,
    input  req_ready, cmdstb, envstart, envlength, ampx, freqaddr, pini,
           grant_id, late_cnt
  );
endinterface

// File: rtl/element_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// element_cmd_arbiter
// Shares one element command port between NREQ cores. A winner is chosen
// round-robin, its command is held until the element tcnt reaches the
// requested trigger time (wrap-safe), then issued with a one-cycle cmdstb and
// a one-cycle req_ready pulse to the winner. After each issue the arbiter
// idles GUARD cycles so the element busy flag has settled before sampling.
// Ports:
//   clk   : element clock
//   reset : synchronous, active-high
//   bus   : element_cmd_arbiter_if.slave (requests, tcnt/busy, issued cmd)
// Optional build macro:
//   ELEMARB_STRICT_PRIORITY_EN : lowest valid index always wins, no rr pointer
// ---------------------------------------------------------------------------
module element_cmd_arbiter #(
  parameter int NREQ           = 4,
  parameter int ENV_ADDRWIDTH  = 32,
  parameter int FREQ_ADDRWIDTH = 32,
  parameter int TCNTWIDTH      = 27,
  parameter int GUARD          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  element_cmd_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GCW-1:0] GUARD_LAST = GCW'((GUARD > 0) ? GUARD - 1 : 0);

  typedef enum logic [2:0] {IDLE, LATCH, WAIT_T, ISSUE, HOLD} state_e;

  typedef struct packed {
    logic [ENV_ADDRWIDTH-1:0]  envstart;
    logic [ENV_ADDRWIDTH-1:0]  envlength;
    logic [15:0]               ampx;
    logic [FREQ_ADDRWIDTH-1:0] freqaddr;
    logic [16:0]               pini;
  } cmd_t;

  state_e               state_q, state_d;
  logic [IDW-1:0]       win_q, win_d;
  logic [IDW-1:0]       sel;
  logic [IDW-1:0]       idx;
  cmd_t                 held_q, held_d;
  cmd_t                 cmd_q, cmd_d;
  logic [TCNTWIDTH-1:0] trigt_q, trigt_d;
  logic [TCNTWIDTH-1:0] delta;
  logic                 cmdstb_q, cmdstb_d;
  logic [NREQ-1:0]      ready_q, ready_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [15:0]          late_q, late_d;
  logic [GCW-1:0]       guard_q, guard_d;
`ifndef ELEMARB_STRICT_PRIORITY_EN
  logic [IDW-1:0]       rr_q, rr_d;
`endif

  // Winner selection. The loop runs from the far end towards the start so
  // the last assignment, i.e. the nearest valid index, is the one that sticks.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ELEMARB_STRICT_PRIORITY_EN
      idx = IDW'(k);
`else
      idx = IDW'((int'(rr_q) + k) % NREQ);
`endif
      if (bus.req_valid[idx]) sel = idx;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    win_d    = win_q;
    held_d   = held_q;
    trigt_d  = trigt_q;
    cmd_d    = cmd_q;
    cmdstb_d = 1'b0;
    ready_d  = '0;
    grant_d  = grant_q;
    late_d   = late_q;
    guard_d  = guard_q;
`ifndef ELEMARB_STRICT_PRIORITY_EN
    rr_d     = rr_q;
`endif
    // Modular distance to the trigger: zero is on time, MSB set means the
    // trigger lies in the past, which stays correct across tcnt rollover.
    delta = trigt_q - bus.tcnt;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid && !bus.elem_busy) state_d = LATCH;
      end
      LATCH: begin
        if (|bus.req_valid) begin
          win_d            = sel;
          held_d.envstart  = bus.req_envstart[int'(sel)*ENV_ADDRWIDTH +: ENV_ADDRWIDTH];
          held_d.envlength = bus.req_envlength[int'(sel)*ENV_ADDRWIDTH +: ENV_ADDRWIDTH];
          held_d.ampx      = bus.req_ampx[int'(sel)*16 +: 16];
          held_d.freqaddr  = bus.req_freqaddr[int'(sel)*FREQ_ADDRWIDTH +: FREQ_ADDRWIDTH];
          held_d.pini      = bus.req_pini[int'(sel)*17 +: 17];
          trigt_d          = bus.req_trigt[int'(sel)*TCNTWIDTH +: TCNTWIDTH];
          state_d          = WAIT_T;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_T: begin
        if (delta == '0 || delta[TCNTWIDTH-1]) begin
          // Issue outputs are loaded on the transition so that they are
          // visible, registered, during the ISSUE cycle itself.
          state_d        = ISSUE;
          cmdstb_d       = 1'b1;
          ready_d[win_q] = 1'b1;
          cmd_d          = held_q;
          grant_d        = win_q;
`ifndef ELEMARB_STRICT_PRIORITY_EN
          rr_d = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
          if (delta != '0 && late_q != 16'hFFFF) late_d = late_q + 16'd1;
        end
      end
      ISSUE: begin
        guard_d = '0;
        state_d = (GUARD == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (guard_q == GUARD_LAST) state_d = IDLE;
        else                       guard_d = guard_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      cmdstb_q <= 1'b0;
      ready_q  <= '0;
      grant_q  <= '0;
      late_q   <= '0;
      guard_q  <= '0;
`ifndef ELEMARB_STRICT_PRIORITY_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmdstb_q <= cmdstb_d;
      ready_q  <= ready_d;
      grant_q  <= grant_d;
      late_q   <= late_d;
      guard_q  <= guard_d;
`ifndef ELEMARB_STRICT_PRIORITY_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // NOTE: the holding registers carry no reset; LATCH always writes them
  // before WAIT_T or ISSUE can read them, and reset forces the FSM to IDLE.
  always_ff @(posedge clk) begin
    win_q   <= win_d;
    held_q  <= held_d;
    trigt_q <= trigt_d;
  end

  assign bus.cmdstb    = cmdstb_q;
  assign bus.req_ready = ready_q;
  assign bus.envstart  = cmd_q.envstart;
  assign bus.envlength = cmd_q.envlength;
  assign bus.ampx      = cmd_q.ampx;
  assign bus.freqaddr  = cmd_q.freqaddr;
  assign bus.pini      = cmd_q.pini;
  assign bus.grant_id  = grant_q;
  assign bus.late_cnt  = late_q;

endmodule

// File: tb/tb_element_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_element_cmd_arbiter
// Directed scenarios followed by a randomized phase, all checked against a
// transaction-level model: the winner is derived from the pending-request
// mask with round-robin (or lowest-index) arithmetic, fields come from what
// the bench handed each requester, lateness from trigt versus the tcnt the
// arbiter saw on the issuing edge.
// cmdstb is registered on the edge at which tcnt==trigt is seen, so an
// on-time issue shows edge_tcnt == trigt for the strobe cycle.
// ---------------------------------------------------------------------------
module tb_element_cmd_arbiter;
  localparam int NREQ  = 4;
  localparam int EW    = 32;
  localparam int FW    = 32;
  localparam int TW    = 27;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  element_cmd_arbiter_if #(.NREQ(NREQ), .ENV_ADDRWIDTH(EW), .FREQ_ADDRWIDTH(FW),
                           .TCNTWIDTH(TW)) bus ();

  element_cmd_arbiter #(.NREQ(NREQ), .ENV_ADDRWIDTH(EW), .FREQ_ADDRWIDTH(FW),
                        .TCNTWIDTH(TW), .GUARD(GUARD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Requester side and element time base
  logic [NREQ-1:0] valid;
  logic [EW-1:0]   r_envstart [NREQ];
  logic [EW-1:0]   r_envlength[NREQ];
  logic [15:0]     r_ampx     [NREQ];
  logic [FW-1:0]   r_freq     [NREQ];
  logic [16:0]     r_pini     [NREQ];
  logic [TW-1:0]   r_trigt    [NREQ];
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   edge_tcnt;
  logic            busy;
  int              cyc;

  // Reference model state
  int rr_m;
  int late_m;
  int last_stb_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] m, input int rr);
`ifdef ELEMARB_STRICT_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic drive();
    bus.req_valid = valid;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_envstart [i*EW +: EW] = r_envstart[i];
      bus.req_envlength[i*EW +: EW] = r_envlength[i];
      bus.req_ampx     [i*16 +: 16] = r_ampx[i];
      bus.req_freqaddr [i*FW +: FW] = r_freq[i];
      bus.req_pini     [i*17 +: 17] = r_pini[i];
      bus.req_trigt    [i*TW +: TW] = r_trigt[i];
    end
    bus.tcnt      = tcnt;
    bus.elem_busy = busy;
  endtask

  // One clock: remember the tcnt the DUT sampled, advance tcnt, sample outputs.
  task automatic tick();
    @(posedge clk);
    edge_tcnt = tcnt;
    #1;
    cyc++;
    tcnt = tcnt + 1'b1;
    drive();
    check("ready_only_with_stb", bus.req_ready & ~{NREQ{bus.cmdstb}}, 0);
  endtask

  task automatic raise(input int i, input int off);
    valid[i]       = 1'b1;
    r_envstart[i]  = $urandom;
    r_envlength[i] = $urandom;
    r_ampx[i]      = 16'($urandom);
    r_freq[i]      = $urandom;
    r_pini[i]      = 17'($urandom);
    r_trigt[i]     = tcnt + TW'(off);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset        = 1'b0;
    rr_m         = 0;
    late_m       = 0;
    last_stb_cyc = -1;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cmdstb && n < budget);
    if (!bus.cmdstb) check("strobe_timeout", bus.cmdstb, 1);
  endtask

  // Compare one observed issue with the model and advance the model.
  task automatic expect_issue(output int w);
    logic [TW-1:0] d;
    w = pick(valid, rr_m);
    if (w < 0) begin
      check("issue_without_request", bus.cmdstb, 0);
      return;
    end
    check("req_ready", bus.req_ready, 64'(1) << w);
    check("envstart",  bus.envstart,  r_envstart[w]);
    check("envlength", bus.envlength, r_envlength[w]);
    check("ampx",      bus.ampx,      r_ampx[w]);
    check("freqaddr",  bus.freqaddr,  r_freq[w]);
    check("pini",      bus.pini,      r_pini[w]);
    check("grant_id",  bus.grant_id,  w);
    d = r_trigt[w] - edge_tcnt;
    check("not_early", (d == '0) || d[TW-1], 1);
    if (d != '0 && late_m < 65535) late_m++;
    check("late_cnt", bus.late_cnt, late_m);
    if (last_stb_cyc >= 0) check("min_spacing", (cyc - last_stb_cyc) >= GUARD + 4, 1);
    last_stb_cyc = cyc;
`ifndef ELEMARB_STRICT_PRIORITY_EN
    rr_m = (w + 1) % NREQ;
`endif
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int issues;

    reset = 1'b1;
    valid = '0;
    busy  = 1'b0;
    cyc   = 0;
    tcnt  = TW'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      r_envstart[i] = '0; r_envlength[i] = '0; r_ampx[i] = '0;
      r_freq[i] = '0; r_pini[i] = '0; r_trigt[i] = '0;
    end
    drive();
    do_reset();

    // Reset state
    check("rst_cmdstb",    bus.cmdstb,    0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_envstart",  bus.envstart,  0);
    check("rst_envlength", bus.envlength, 0);
    check("rst_ampx",      bus.ampx,      0);
    check("rst_freqaddr",  bus.freqaddr,  0);
    check("rst_pini",      bus.pini,      0);
    check("rst_grant_id",  bus.grant_id,  0);
    check("rst_late_cnt",  bus.late_cnt,  0);

    // Single request, trigger 20 ahead: strobe on the edge seeing tcnt==trigt
    raise(0, 20);
    drive();
    wait_strobe(100, n);
    if (bus.cmdstb) begin
      check("t1_wait_cycles", n, 21);
      check("t1_ontime", edge_tcnt, r_trigt[0]);
      expect_issue(w);
    end
    valid = '0;
    drive();

    // All requesters valid with past triggers: rotation, spacing, late count
    do_reset();
    for (int i = 0; i < NREQ; i++) raise(i, -100);
    drive();
    for (int k = 0; k < 5; k++) begin
      wait_strobe(50, n);
      if (k == 0) check("t2_latency", n, 3);
      else        check("t2_spacing", n, GUARD + 4);
      if (bus.cmdstb) begin
        expect_issue(w);
        if (k == 3) check("t2_late4", bus.late_cnt, 4);
        if (w >= 0) raise(w, -100);
        drive();
      end
    end
    valid = '0;
    drive();

    // Element busy blocks issue; issue 3 cycles after busy falls
    do_reset();
    busy = 1'b1;
    raise(2, -50);
    drive();
    for (int k = 0; k < 100; k++) begin
      tick();
      check("t3_no_stb_busy", bus.cmdstb, 0);
    end
    busy = 1'b0;
    drive();
    wait_strobe(20, n);
    check("t3_latency", n, 3);
    if (bus.cmdstb) expect_issue(w);
    valid = '0;
    drive();

    // tcnt rollover: tcnt=2^TW-5, trigt=3 -> decision on the edge seeing 3
    do_reset();
    tcnt = '1 - TW'(4);
    raise(0, 0);
    r_trigt[0] = TW'(3);
    drive();
    wait_strobe(30, n);
    check("t4_wait_cycles", n, 9);
    if (bus.cmdstb) begin
      check("t4_edge_tcnt", edge_tcnt, 3);
      expect_issue(w);
    end
    valid = '0;
    drive();

    // Reset while waiting for a trigger aborts the command
    do_reset();
    raise(3, -10);
    drive();
    wait_strobe(30, n);
    if (bus.cmdstb) expect_issue(w);
    valid[3] = 1'b0;
    raise(1, 60);
    drive();
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t5_no_stb_wait", bus.cmdstb, 0);
    end
    check("t5_late_before", bus.late_cnt, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_cmdstb",   bus.cmdstb,    0);
    check("t5_rst_ready",    bus.req_ready, 0);
    check("t5_rst_late_cnt", bus.late_cnt,  0);
    check("t5_rst_grant_id", bus.grant_id,  0);
    rr_m = 0; late_m = 0; last_stb_cyc = -1;
    wait_strobe(100, n);
    if (bus.cmdstb) begin
      check("t5_reissue_ontime", edge_tcnt, r_trigt[1]);
      expect_issue(w);
    end
    valid = '0;
    drive();

`ifdef ELEMARB_STRICT_PRIORITY_EN
    // Strict priority: requester 0 keeps winning over requester 1
    do_reset();
    raise(0, -5);
    raise(1, -5);
    drive();
    for (int k = 0; k < 6; k++) begin
      wait_strobe(30, n);
      check("t6_ready_is_0", bus.req_ready, 1);
      check("t6_grant_is_0", bus.grant_id, 0);
      if (bus.cmdstb) begin
        expect_issue(w);
        if (w >= 0) raise(w, -5);
        drive();
      end
    end
    valid = '0;
    drive();
`endif

    // Randomized traffic across a tcnt rollover. New requests appear only on
    // an ack cycle or when nothing is pending, so the pending mask seen at the
    // strobe is the one the arbiter arbitrated over.
    do_reset();
    tcnt   = '1 - TW'(300);
    issues = 0;
    drive();
    for (int t = 0; t < 30000 && issues < 150; t++) begin
      busy = ($urandom_range(0, 7) == 0);
      drive();
      tick();
      if (bus.cmdstb) begin
        expect_issue(w);
        if (w >= 0) valid[w] = 1'b0;
        issues++;
        for (int i = 0; i < NREQ; i++)
          if (!valid[i] && $urandom_range(0, 1) == 1) raise(i, int'($urandom_range(0, 80)) - 40);
        drive();
      end else if (valid == '0 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NREQ; i++)
          if ($urandom_range(0, 1) == 1) raise(i, int'($urandom_range(0, 80)) - 40);
        drive();
      end
    end
    check("t7_issue_count", issues, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/element_cmd_arbiter.md
Name: element_cmd_arbiter

Overview:
- Shares one element command port (envstart/envlength/ampx/freqaddr/pini/cmdstb) between NREQ processor cores.
- Round-robin arbitration, timestamped dispatch against the element tcnt, and issue gating on the element busy flag.
- Sits between the per-core command decoders and the element proc modport; one instance per shared element.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ENV_ADDRWIDTH, 32, width of envstart/envlength.
- FREQ_ADDRWIDTH, 32, width of freqaddr.
- TCNTWIDTH, 27, width of tcnt and trigger timestamps.
- GUARD, 2, idle cycles after each cmdstb before elem_busy is sampled again (covers busy_r registration latency).

Ports:
- clk  in  1  element clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  one-cycle pulse on the winner's bit when its command is issued.
- req_envstart  in  NREQ*ENV_ADDRWIDTH  packed, requester i at slice i.
- req_envlength  in  NREQ*ENV_ADDRWIDTH  packed.
- req_ampx  in  NREQ*16  packed.
- req_freqaddr  in  NREQ*FREQ_ADDRWIDTH  packed.
- req_pini  in  NREQ*17  packed.
- req_trigt  in  NREQ*TCNTWIDTH  requested issue time.
- tcnt  in  TCNTWIDTH  element time counter.
- elem_busy  in  1  element busy (busy_r|cmdstb).
- cmdstb  out  1  one-cycle command strobe to the element.
- envstart  out  ENV_ADDRWIDTH  issued field.
- envlength  out  ENV_ADDRWIDTH  issued field.
- ampx  out  16  issued field.
- freqaddr  out  FREQ_ADDRWIDTH  issued field.
- pini  out  17  issued field.
- grant_id  out  $clog2(NREQ)  index of the last issued requester.
- late_cnt  out  16  saturating count of late issues.

Behaviour:
- All outputs are registered. Reset values: cmdstb=0, req_ready=0, all fields=0, grant_id=0, late_cnt=0, rr pointer=0, state=IDLE.
- Reset mid-operation aborts any pending command. The requester is not acked and must keep req_valid asserted.
- FSM states: IDLE, LATCH, WAIT_T, ISSUE, HOLD.
- IDLE: if |req_valid && !elem_busy, go to LATCH.
- LATCH: pick the winner as the first valid index at or after the rr pointer, wrapping modulo NREQ. Capture its fields and trigt into holding registers. Go to WAIT_T. If no request is valid (withdrawn), return to IDLE.
- WAIT_T: compute d = trigt - tcnt, modulo 2^TCNTWIDTH.
  - d==0: go to ISSUE (on time).
  - d MSB set (past): go to ISSUE and increment late_cnt, saturating at 16'hFFFF.
  - Otherwise stay in WAIT_T.
  - This comparison is wrap-safe across tcnt rollover.
- ISSUE: drive the held fields, cmdstb=1 and req_ready[winner]=1 for exactly one cycle. grant_id <= winner. rr pointer <= winner+1 mod NREQ. Go to HOLD.
- HOLD: count GUARD cycles, then go to IDLE. Fields stay stable until the next ISSUE.
- Latency: with elem_busy low and trigt already past at LATCH, cmdstb asserts 3 cycles after req_valid rises (IDLE→LATCH→WAIT_T→ISSUE, registered).
- Minimum spacing between cmdstb pulses is GUARD+4 cycles.
- A requester changing its fields while valid and not yet acked is undefined. Fields are sampled only in LATCH.
- A requester deasserting valid after LATCH still gets issued and acked.
- Simultaneous requests are resolved by round-robin only. No starvation: each valid requester is served within NREQ issues.

Optional Feature:
- Macro ELEMARB_STRICT_PRIORITY_EN.
- Defined: LATCH selects the lowest valid index regardless of the rr pointer. The rr pointer is not updated. Index 0 can starve others.
- Undefined: round-robin as above.

Test Plan:
- Single request: req_valid=4'b0001, trigt=tcnt+20, elem_busy=0 → one cmdstb exactly when tcnt==trigt, req_ready=4'b0001 in the same cycle, fields match slice 0, late_cnt=0.
- All four valid, trigt in the past, busy low → cmdstb order 0,1,2,3,0; grant_id follows; late_cnt=4 after four issues; spacing = GUARD+4 cycles.
- elem_busy held high for 100 cycles with req_valid=4'b0100 → no cmdstb during those cycles; issue 3 cycles after busy falls (trigt past).
- tcnt wrap: tcnt=2^27-5, trigt=3 → issue when tcnt==3 (8 cycles later), not immediately; late_cnt unchanged.
- reset asserted in WAIT_T → next cycle state IDLE, cmdstb=0, no req_ready, late_cnt=0; request reissued after reset release.
- With ELEMARB_STRICT_PRIORITY_EN, req_valid=4'b0011 held → requester 0 repeatedly granted, requester 1 never granted.
